r16_lane_gather: RTL and testbench
==================================

Name: r16_lane_gather

Overview:
- Serial-to-parallel front end for the radix-16, 16384-point pipelined transform.
- Accepts one D_WIDTH sample per cycle over a valid/ready handshake and packs each run of 16 consecutive samples into one 16-lane group.
- Presents each group on R0_out..R15_out, directly feeding the first 16-lane pipeline register stage.
- Ping-pong double buffer: input streaming continues while a finished group waits for downstream.

Parameters:
D_WIDTH, 192, sample width in bits
FRAME_GROUPS, 1024, 16-lane groups per transform frame (16384/16)
GRP_CNT_W, 10, width of group counter; must satisfy 2^GRP_CNT_W >= FRAME_GROUPS

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset; synchronous, active-low (sampled on rising edge of clk)
in_data  input  D_WIDTH  serial input sample
in_valid  input  1  in_data valid
in_ready  output  1  block can accept in_data this cycle
R0_out..R15_out  output  D_WIDTH each  lane k = k-th sample of the group
out_valid  output  1  R0_out..R15_out hold a complete group
out_ready  input  1  downstream consumes group this cycle
out_last  output  1  current group is last of frame (group FRAME_GROUPS-1)

Behaviour:
- State: two banks of 16 x D_WIDTH registers; full[1:0]; wbank (write bank), rbank (read bank); 4-bit fill counter cnt; GRP_CNT_W-bit group counter grp.
- Reset (rst_n low at clk edge): bank data, full, wbank, rbank, cnt, grp all 0. Reset takes priority over any handshake in the same cycle; a partial group or pending output is discarded.
- Reset output values: R*_out=0, out_valid=0, out_last=0. in_ready is 0 while rst_n is low and 1 on the first cycle after release.
- in_ready = rst_n & ~full[wbank] (combinational from registered state; no combinational path from in_valid or out_ready).
- Input accept when in_valid & in_ready: bank[wbank][lane(cnt)] <= in_data; cnt <= cnt+1 (wraps 15->0).
- When the accept has cnt==15: full[wbank] <= 1; wbank toggles.
- out_valid = full[rbank]. R*_out drive bank[rbank] lanes combinationally from registers and stay stable while out_valid=1 and out_ready=0.
- Output handshake when out_valid & out_ready: full[rbank] <= 0; rbank toggles; grp <= (grp==FRAME_GROUPS-1) ? 0 : grp+1.
- out_last = out_valid & (grp==FRAME_GROUPS-1).
- Latency: out_valid rises on the cycle after the 16th accepted sample of a group.
- Simultaneous accept-completion and output release always target different banks; both take effect in the same cycle.
- Throughput: sustains 1 sample/cycle with out_ready held high. With both banks full, in_ready=0 until a release; in_ready then returns to 1 on the cycle after the release.
- in_valid low mid-group: cnt holds and partial bank data is retained; there is no timeout.
- lane(k) = k by default (see Optional Feature).

Optional Feature:
- Macro GATHER_DIGIT_REV_EN.
- Defined: lane(k) = 4-bit bit-reverse of k. Sample k lands on lane bitrev4(k), e.g. sample 1 -> R8_out, sample 3 -> R12_out.
- Undefined: lane(k) = k (natural order). Handshake, latency and counters are identical in both builds.

Test Plan:
- Reset, then stream in_data=1..16 with in_valid=1 and out_ready=1 -> out_valid=1 exactly one cycle after 16th accept; Rk_out=k+1 for k=0..15; out_valid drops the next cycle.
- out_ready=0, stream 48 samples continuously -> in_ready falls after sample 32. Groups hold values 1..16 and 17..32. After out_ready pulses for one cycle, in_ready=1 on the next cycle and samples 33..48 form group 3 with no loss or duplication.
- Continuous 16384-sample frame, out_ready=1 -> 1024 out_valid pulses; out_last=1 only on the 1024th; the next frame's first group has out_last=0.
- Feed 7 samples, assert rst_n=0 for one cycle mid-group, then feed 16 samples A0..A15 -> first group is exactly A0..A15 (R0_out=A0); no stale data appears.
- In_valid toggling 1/0 every cycle with random out_ready stalls of 0-5 cycles -> output group sequence matches scoreboard, and R*_out never change while out_valid=1 and out_ready=0.
- GATHER_DIGIT_REV_EN defined, input 0..15 -> R0=0, R1=8, R2=4, R3=12, R8=1, R15=15.

Source files
------------

// File: rtl/r16_lane_gather.sv
// Serial-to-parallel gather: packs 16 consecutive samples into one 16-lane group
// through a ping-pong double buffer. Define GATHER_DIGIT_REV_EN for bit-reversed lane order.
module r16_lane_gather #(
  parameter int D_WIDTH      = 192,
  parameter int FRAME_GROUPS = 1024,
  parameter int GRP_CNT_W    = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [D_WIDTH-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [D_WIDTH-1:0] R0_out,
  output logic [D_WIDTH-1:0] R1_out,
  output logic [D_WIDTH-1:0] R2_out,
  output logic [D_WIDTH-1:0] R3_out,
  output logic [D_WIDTH-1:0] R4_out,
  output logic [D_WIDTH-1:0] R5_out,
  output logic [D_WIDTH-1:0] R6_out,
  output logic [D_WIDTH-1:0] R7_out,
  output logic [D_WIDTH-1:0] R8_out,
  output logic [D_WIDTH-1:0] R9_out,
  output logic [D_WIDTH-1:0] R10_out,
  output logic [D_WIDTH-1:0] R11_out,
  output logic [D_WIDTH-1:0] R12_out,
  output logic [D_WIDTH-1:0] R13_out,
  output logic [D_WIDTH-1:0] R14_out,
  output logic [D_WIDTH-1:0] R15_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last
);

  localparam logic [GRP_CNT_W-1:0] LAST_GRP = GRP_CNT_W'(FRAME_GROUPS - 1);

  logic [D_WIDTH-1:0]   bank_q [2][16];
  logic [1:0]           full_q, full_d;
  logic                 wbank_q, wbank_d;
  logic                 rbank_q, rbank_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [GRP_CNT_W-1:0] grp_q, grp_d;
  logic                 in_fire, out_fire;
  logic [3:0]           lane_sel;

  function automatic logic [3:0] lane_of(input logic [3:0] k);
`ifdef GATHER_DIGIT_REV_EN
    return {k[0], k[1], k[2], k[3]};
`else
    return k;
`endif
  endfunction

  assign in_ready  = rst_n & ~full_q[wbank_q];
  assign out_valid = full_q[rbank_q];
  assign out_last  = out_valid & (grp_q == LAST_GRP);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign lane_sel  = lane_of(cnt_q);

  // Fill completion and output release always touch different banks,
  // so both updates to full_d can land in the same cycle.
  always_comb begin
    full_d  = full_q;
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    cnt_d   = cnt_q;
    grp_d   = grp_q;
    if (in_fire) begin
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd15) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end
    end
    if (out_fire) begin
      full_d[rbank_q] = 1'b0;
      rbank_d         = ~rbank_q;
      grp_d           = (grp_q == LAST_GRP) ? '0 : grp_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q  <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      cnt_q   <= '0;
      grp_q   <= '0;
    end else begin
      full_q  <= full_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      cnt_q   <= cnt_d;
      grp_q   <= grp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int l = 0; l < 16; l++) begin
          bank_q[b][l] <= '0;
        end
      end
    end else if (in_fire) begin
      bank_q[wbank_q][lane_sel] <= in_data;
    end
  end

  assign R0_out  = bank_q[rbank_q][0];
  assign R1_out  = bank_q[rbank_q][1];
  assign R2_out  = bank_q[rbank_q][2];
  assign R3_out  = bank_q[rbank_q][3];
  assign R4_out  = bank_q[rbank_q][4];
  assign R5_out  = bank_q[rbank_q][5];
  assign R6_out  = bank_q[rbank_q][6];
  assign R7_out  = bank_q[rbank_q][7];
  assign R8_out  = bank_q[rbank_q][8];
  assign R9_out  = bank_q[rbank_q][9];
  assign R10_out = bank_q[rbank_q][10];
  assign R11_out = bank_q[rbank_q][11];
  assign R12_out = bank_q[rbank_q][12];
  assign R13_out = bank_q[rbank_q][13];
  assign R14_out = bank_q[rbank_q][14];
  assign R15_out = bank_q[rbank_q][15];

endmodule

// File: tb/tb_r16_lane_gather.sv
// Self-checking bench for r16_lane_gather: a queue-based group model checked every cycle,
// plus directed literal checks for latency, back-pressure, frame marking and mid-group reset.
module tb_r16_lane_gather;
  localparam int D  = 192;
  localparam int FG = 1024;
  localparam int GW = 10;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [D-1:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [D-1:0]   r_out [16];
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           out_last;

  r16_lane_gather #(.D_WIDTH(D), .FRAME_GROUPS(FG), .GRP_CNT_W(GW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .R0_out(r_out[0]),   .R1_out(r_out[1]),   .R2_out(r_out[2]),   .R3_out(r_out[3]),
    .R4_out(r_out[4]),   .R5_out(r_out[5]),   .R6_out(r_out[6]),   .R7_out(r_out[7]),
    .R8_out(r_out[8]),   .R9_out(r_out[9]),   .R10_out(r_out[10]), .R11_out(r_out[11]),
    .R12_out(r_out[12]), .R13_out(r_out[13]), .R14_out(r_out[14]), .R15_out(r_out[15]),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [D-1:0] act, input logic [D-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Which lane sample k of a group lands on
  function automatic int lane_of(input int k);
`ifdef GATHER_DIGIT_REV_EN
    return ((k & 1) << 3) | ((k & 2) << 1) | ((k & 4) >> 1) | ((k & 8) >> 3);
`else
    return k;
`endif
  endfunction

  function automatic logic [D-1:0] rand_data();
    logic [D-1:0] r = '0;
    for (int i = 0; i < (D + 31) / 32; i++) r = (r << 32) | D'($urandom());
    return r;
  endfunction

  // Reference model: completed groups waiting for downstream, and the partial group being filled
  typedef logic [16*D-1:0] grp_t;
  grp_t         exp_q[$];
  logic [D-1:0] partial[$];
  int           released_total = 0;

  function automatic bit m_ready();
    return rst_n && (exp_q.size() < 2);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      partial.delete();
      released_total = 0;
    end else begin
      bit acc, rel;
      acc = in_valid && m_ready();
      rel = (exp_q.size() > 0) && out_ready;
      if (rel) begin
        void'(exp_q.pop_front());
        released_total++;
      end
      if (acc) begin
        partial.push_back(in_data);
        if (partial.size() == 16) begin
          grp_t g = '0;
          for (int j = 0; j < 16; j++) g[lane_of(j)*D +: D] = partial[j];
          exp_q.push_back(g);
          partial.delete();
        end
      end
    end
  end

  // Per-cycle compare, plus hold-stability and release counting
  bit           started = 1'b0;
  bit           prev_hold = 1'b0;
  logic [D-1:0] prev_lanes [16];
  int           rel_cnt = 0, last_cnt = 0, last_idx = -1;

  always @(negedge clk) begin
    if (started) begin
      bit mv, ml;
      mv = exp_q.size() > 0;
      ml = mv && ((released_total % FG) == FG - 1);
      chk("in_ready", D'(in_ready), D'(m_ready()));
      chk("out_valid", D'(out_valid), D'(mv));
      chk("out_last", D'(out_last), D'(ml));
      if (mv) begin
        for (int k = 0; k < 16; k++) chk($sformatf("lane%0d", k), r_out[k], exp_q[0][k*D +: D]);
      end
      if (prev_hold && rst_n) begin
        chk("hold_valid", D'(out_valid), D'(1));
        for (int k = 0; k < 16; k++) chk($sformatf("hold_lane%0d", k), r_out[k], prev_lanes[k]);
      end
      if (rst_n && out_valid && out_ready) begin
        rel_cnt++;
        if (out_last) begin
          last_cnt++;
          last_idx = rel_cnt;
        end
      end
      prev_hold = rst_n && out_valid && !out_ready;
      for (int k = 0; k < 16; k++) prev_lanes[k] = r_out[k];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [D-1:0] d);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 300) begin
        checks++;
        failures++;
        $display("FAIL send_timeout actual=in_ready_low required=accept");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_empty", D'(exp_q.size()), D'(0));
    tick();
  endtask

  int lit_lane[6] = '{0, 1, 2, 3, 8, 15};
`ifdef GATHER_DIGIT_REV_EN
  int base = 0;
  int lit_val[6] = '{0, 8, 4, 12, 1, 15};
`else
  int base = 1;
  int lit_val[6] = '{1, 2, 3, 4, 9, 16};
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [D-1:0] a0;
    bit done;

    // Reset state
    @(posedge clk);
    started = 1'b1;
    #1;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_in_ready", D'(in_ready), D'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", D'(in_ready), D'(1));
    chk("post_rst_out_valid", D'(out_valid), D'(0));
    chk("post_rst_out_last", D'(out_last), D'(0));
    chk("post_rst_R0", r_out[0], '0);
    chk("post_rst_R15", r_out[15], '0);
    @(posedge clk); #1;

    // One group, out_ready high: valid one cycle after the 16th accept, then drops
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) send(D'(base + i));
    in_valid = 1'b0;
    chk("g1_valid", D'(out_valid), D'(1));
    for (int i = 0; i < 6; i++) chk($sformatf("g1_R%0d", lit_lane[i]), r_out[lit_lane[i]], D'(lit_val[i]));
    tick();
    chk("g1_valid_drop", D'(out_valid), D'(0));

    // Back-pressure: both banks fill, in_ready falls, one release reopens input
    out_ready = 1'b0;
    for (int i = 1; i <= 32; i++) send(D'(100 + i));
    in_data = D'(133);
    @(negedge clk);
    chk("bp_in_ready_low", D'(in_ready), D'(0));
    chk("bp_R0", r_out[0], D'(101));
    chk("bp_R15", r_out[15], D'(116));
    repeat (3) tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_still_low", D'(in_ready), D'(0));
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_in_ready_back", D'(in_ready), D'(1));
    chk("bp_second_R0", r_out[0], D'(117));
    for (int i = 33; i <= 48; i++) send(D'(100 + i));
    drain();

    // Full frame plus one group, continuous streaming
    do_reset(1);
    rel_cnt = 0; last_cnt = 0; last_idx = -1;
    out_ready = 1'b1;
    for (int i = 0; i < 16 * (FG + 1); i++) send(rand_data());
    drain();
    chk("frame_groups", D'(rel_cnt), D'(FG + 1));
    chk("frame_last_count", D'(last_cnt), D'(1));
    chk("frame_last_index", D'(last_idx), D'(FG));

    // Reset mid-group discards the partial group
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(rand_data());
    do_reset(1);
    a0 = rand_data();
    send(a0);
    for (int i = 1; i < 16; i++) send(rand_data());
    in_valid = 1'b0;
    chk("mid_rst_valid", D'(out_valid), D'(1));
    chk("mid_rst_R0", r_out[0], a0);
    drain();

    // Gapped input against random downstream stalls
    done = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 16 * 12; i++) begin
          send(rand_data());
          in_valid = 1'b0;
          tick();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'b0;
          repeat ($urandom_range(0, 5)) tick();
          out_ready = 1'b1;
          tick();
        end
      end
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
